// File: rtl/hazard_forwarding_unit.sv
// hazard_forwarding_unit
//   Tracks destination/write-enable information for the EX, MEM and WB
//   stages and derives the ID-stage operand forwarding selects, the PC and
//   IF/ID load enables and the ID/EX bubble request for load-use hazards.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   ID_RS / ID_RT         source registers of the instruction in ID
//   ID_USES_RS/RT         the instruction actually reads that source
//   ID_DEST               destination register of the instruction in ID
//   ID_RF_ENABLE          the instruction writes the register file
//   ID_LOAD_INSTR         the instruction is a load
//   FWD_A_SEL/FWD_B_SEL   operand mux selects: 00 RF, 01 EX, 10 MEM, 11 WB
//   PC_LE, IF_ID_LE       load enables, dropped for one cycle on a load-use
//   ID_EX_NOP             ID/EX captures a bubble
//   OUT_reg*/OUT_Enable*  scoreboard contents per stage
//   STALL_COUNT           saturating count of load-use stall cycles
module hazard_forwarding_unit #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [REG_W-1:0] ID_RS,
   input  logic [REG_W-1:0] ID_RT,
   input  logic             ID_USES_RS,
   input  logic             ID_USES_RT,
   input  logic [REG_W-1:0] ID_DEST,
   input  logic             ID_RF_ENABLE,
   input  logic             ID_LOAD_INSTR,
   output logic [1:0]       FWD_A_SEL,
   output logic [1:0]       FWD_B_SEL,
   output logic             PC_LE,
   output logic             IF_ID_LE,
   output logic             ID_EX_NOP,
   output logic [REG_W-1:0] OUT_regEX,
   output logic [REG_W-1:0] OUT_regMEM,
   output logic [REG_W-1:0] OUT_regWB,
   output logic             OUT_EnableEX,
   output logic             OUT_EnableMEM,
   output logic             OUT_EnableWB,
   output logic [CNT_W-1:0] STALL_COUNT
);

   typedef enum logic [1:0] {
      SEL_RF  = 2'b00,
      SEL_EX  = 2'b01,
      SEL_MEM = 2'b10,
      SEL_WB  = 2'b11
   } fwd_sel_t;

   // Scoreboard slots. The load flag only influences the EX slot (a load
   // one stage further can always be forwarded), so it is not carried on.
   logic [REG_W-1:0] ex_dest, mem_dest, wb_dest;
   logic             ex_en, mem_en, wb_en;
   logic             ex_load;
   logic [CNT_W-1:0] stall_count;

   // Slots writing $0 never match anything.
   logic ex_live, mem_live, wb_live;
   logic stall;
   fwd_sel_t sel_a, sel_b;

   function automatic fwd_sel_t pick_source(
      input logic             used,
      input logic [REG_W-1:0] src,
      input logic             ex_ok,
      input logic             mem_ok,
      input logic             wb_ok
   );
      fwd_sel_t sel;
      sel = SEL_RF;
      if (used && (src != '0)) begin
         // Youngest producer first.
         if (ex_ok && (src == ex_dest))
            sel = SEL_EX;
         else if (mem_ok && (src == mem_dest))
            sel = SEL_MEM;
         else if (wb_ok && (src == wb_dest))
            sel = SEL_WB;
      end
      return sel;
   endfunction

   always_comb begin
      ex_live  = ex_en  && (ex_dest  != '0);
      mem_live = mem_en && (mem_dest != '0);
      wb_live  = wb_en  && (wb_dest  != '0);

      sel_a = pick_source(ID_USES_RS, ID_RS, ex_live, mem_live, wb_live);
      sel_b = pick_source(ID_USES_RT, ID_RT, ex_live, mem_live, wb_live);

      // One stall covers both operands even when RS == RT.
      stall = !Reset && ex_live && ex_load &&
              ((ID_USES_RS && (ID_RS == ex_dest)) ||
               (ID_USES_RT && (ID_RT == ex_dest)));

      FWD_A_SEL = SEL_RF;
      FWD_B_SEL = SEL_RF;
      PC_LE     = 1'b1;
      IF_ID_LE  = 1'b1;
      ID_EX_NOP = 1'b0;
      if (!Reset) begin
         FWD_A_SEL = sel_a;
         FWD_B_SEL = sel_b;
         PC_LE     = !stall;
         IF_ID_LE  = !stall;
         ID_EX_NOP = stall;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_dest     <= '0;
         ex_en       <= 1'b0;
         ex_load     <= 1'b0;
         mem_dest    <= '0;
         mem_en      <= 1'b0;
         wb_dest     <= '0;
         wb_en       <= 1'b0;
         stall_count <= '0;
      end else begin
         wb_dest  <= mem_dest;
         wb_en    <= mem_en;
         mem_dest <= ex_dest;
         mem_en   <= ex_en;
         if (stall) begin
            ex_dest <= '0;
            ex_en   <= 1'b0;
            ex_load <= 1'b0;
         end else begin
            ex_dest <= ID_DEST;
            ex_en   <= ID_RF_ENABLE;
            ex_load <= ID_LOAD_INSTR;
         end
         if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   assign OUT_regEX     = ex_dest;
   assign OUT_regMEM    = mem_dest;
   assign OUT_regWB     = wb_dest;
   assign OUT_EnableEX  = ex_en;
   assign OUT_EnableMEM = mem_en;
   assign OUT_EnableWB  = wb_en;
   assign STALL_COUNT   = stall_count;

endmodule
